blink_period_meter: RTL and testbench



---
 rtl/blink_meter_pkg.sv | 18 +
 rtl/blink_period_meter_if.sv | 15 +
 rtl/period_hold_reg.sv | 46 ++++
 rtl/blink_period_meter.sv | 112 +++++++++++
 tb/tb_blink_period_meter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/blink_meter_pkg.sv
// Shared types and defaults for the blink period meter: FSM states, default widths,
// and the saturating counter step used by the period counter.
package blink_meter_pkg;

  typedef enum logic {
    StIdle,
    StMeasure
  } state_e;

  localparam int unsigned CntWDefault    = 16;
  localparam int unsigned TimeoutDefault = 1024;

  // Caller widens its operands to 32 bits; max_val is the all-ones value of its width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/blink_period_meter_if.sv
// Valid/ready stream carrying measured blink periods from the meter to its consumer.
interface blink_period_meter_if
  import blink_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) ();

  logic             period_valid;
  logic             period_ready;
  logic [CNT_W-1:0] period_data;

  modport master (output period_valid, output period_data, input period_ready);
  modport slave  (input period_valid, input period_data, output period_ready);

endinterface

// File: rtl/period_hold_reg.sv
// One-entry valid/ready holding register. A new sample loads when the slot is empty or
// drains in the same cycle; otherwise it is dropped and drop_o pulses.
module period_hold_reg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             load;

  always_comb begin
    load    = in_valid_i & (~valid_q | out_ready_i);
    drop_o  = in_valid_i & ~load;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/blink_period_meter.sv
// Measures cycles between rising edges of blink_in, streams each period out, keeps
// min/max/edge-count statistics and flags a stalled blinker after TIMEOUT idle cycles.
module blink_period_meter
  import blink_meter_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blink_in,
  input  logic                     clear_in,
  blink_period_meter_if.master     period_if,
  output logic [CNT_W-1:0]         min_period,
  output logic [CNT_W-1:0]         max_period,
  output logic [CNT_W-1:0]         edge_count,
  output logic                     stalled,
  output logic                     overrun
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT - 1);

  logic             blink_q, blink_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d, edge_q, edge_d;
  logic             stalled_q, stalled_d, overrun_q, overrun_d;
  logic             rise, edge_inc, sample_valid, drop;

  always_comb begin
    blink_d      = blink_in;
    rise         = blink_in & ~blink_q;
    cnt_d        = rise ? CNT_W'(1) : CNT_W'(sat_inc(32'(cnt_q), 32'(CntMax)));
    state_d      = state_q;
    stalled_d    = stalled_q;
    sample_valid = 1'b0;
    edge_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d   = StMeasure;
          stalled_d = 1'b0;
          edge_inc  = 1'b1;
        end
      end
      StMeasure: begin
        if (rise) begin
          sample_valid = 1'b1;
          edge_inc     = 1'b1;
        end else if (cnt_q == TimeoutCnt) begin
          stalled_d = 1'b1;
          state_d   = StIdle;
        end
      end
    endcase
  end

  // Clear applies before any coincident sample so that sample seeds the new stats.
  always_comb begin
    min_d     = clear_in ? CntMax : min_q;
    max_d     = clear_in ? '0 : max_q;
    edge_d    = (clear_in ? '0 : edge_q) + CNT_W'(edge_inc);
    overrun_d = (clear_in ? 1'b0 : overrun_q) | drop;
    if (sample_valid) begin
      if (cnt_q < min_d) min_d = cnt_q;
      if (cnt_q > max_d) max_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    // Track blink_in even in reset so a level held high across reset is not a rise.
    blink_q <= blink_d;
    if (rst) begin
      cnt_q     <= '0;
      state_q   <= StIdle;
      min_q     <= CntMax;
      max_q     <= '0;
      edge_q    <= '0;
      stalled_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      edge_q    <= edge_d;
      stalled_q <= stalled_d;
      overrun_q <= overrun_d;
    end
  end

  period_hold_reg #(
    .Width(CNT_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (sample_valid),
    .in_data_i  (cnt_q),
    .out_ready_i(period_if.period_ready),
    .out_valid_o(period_if.period_valid),
    .out_data_o (period_if.period_data),
    .drop_o     (drop)
  );

  assign min_period = min_q;
  assign max_period = max_q;
  assign edge_count = edge_q;
  assign stalled    = stalled_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_blink_period_meter.sv
// Randomised and directed bench: a cycle-indexed reference model predicts periods and
// statistics; a negedge monitor checks each accepted sample against a scoreboard queue.
module tb_blink_period_meter;

  localparam int unsigned CntW = 16;
  localparam int unsigned Tmo  = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic            blink_in;
  logic            clear_in;
  logic [CntW-1:0] min_period, max_period, edge_count;
  logic            stalled, overrun;

  blink_period_meter_if #(.CNT_W(CntW)) period_if ();

  blink_period_meter #(
    .CNT_W  (CntW),
    .TIMEOUT(Tmo)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .blink_in  (blink_in),
    .clear_in  (clear_in),
    .period_if (period_if),
    .min_period(min_period),
    .max_period(max_period),
    .edge_count(edge_count),
    .stalled   (stalled),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: periods are differences of edge indices at which rises occur.
  int          cyc_e = 0;
  int          ref_e = 0;
  bit          measuring, prev_blink, slot_full, model_ok, after_reset;
  logic [15:0] m_min, m_max, m_edge;
  bit          m_stalled, m_overrun;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit b, input bit clr, input bit rdy, input bit r);
    bit rise;
    int per;
    if (r) begin
      prev_blink  = b;
      measuring   = 0;
      slot_full   = 0;
      exp_q.delete();
      m_min       = 16'hffff;
      m_max       = 0;
      m_edge      = 0;
      m_stalled   = 0;
      m_overrun   = 0;
      ref_e       = cyc_e + 1;
      after_reset = 1;
    end else begin
      after_reset = 0;
      rise        = b && !prev_blink;
      prev_blink  = b;
      if (clr) begin
        m_min     = 16'hffff;
        m_max     = 0;
        m_edge    = 0;
        m_overrun = 0;
      end
      if (slot_full && rdy) slot_full = 0;
      per = cyc_e - ref_e;
      if (per > 65535) per = 65535;
      if (rise) begin
        m_edge = m_edge + 16'd1;
        if (!measuring) begin
          measuring = 1;
          m_stalled = 0;
        end else begin
          if (per < int'(m_min)) m_min = per[15:0];
          if (per > int'(m_max)) m_max = per[15:0];
          if (!slot_full) begin
            exp_q.push_back(per[15:0]);
            slot_full = 1;
          end else begin
            m_overrun = 1;
          end
        end
        ref_e = cyc_e;
      end else if (measuring && per == int'(Tmo) - 1) begin
        m_stalled = 1;
        measuring = 0;
      end
    end
    cyc_e++;
  endtask

  task automatic step(input bit b, input bit clr, input bit rdy, input bit r);
    @(posedge clk);
    #2;
    if (model_ok) begin
      check("stalled", int'(stalled), int'(m_stalled));
      check("overrun", int'(overrun), int'(m_overrun));
      check("min_period", int'(min_period), int'(m_min));
      check("max_period", int'(max_period), int'(m_max));
      check("edge_count", int'(edge_count), int'(m_edge));
      check("period_valid", int'(period_if.period_valid), int'(slot_full));
      if (after_reset) check("period_data_reset", int'(period_if.period_data), 0);
    end
    blink_in               = b;
    clear_in               = clr;
    period_if.period_ready = rdy;
    rst                    = r;
    model_edge(b, clr, rdy, r);
    model_ok = 1;
  endtask

  task automatic pulses(input int hi, input int lo, input int n, input int pct, input bit clr_rise);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < hi + lo; j++) begin
        step(j < hi, clr_rise && j == 0, $urandom_range(99) < pct, 0);
      end
    end
  endtask

  task automatic hold(input bit b, input int n, input bit rdy, input bit r);
    for (int i = 0; i < n; i++) step(b, 0, rdy, r);
  endtask

  always @(negedge clk) begin
    if (!rst && period_if.period_valid && period_if.period_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL period_data: got %0d expected none (no sample pending) at %0t",
                 period_if.period_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("period_data", int'(period_if.period_data), int'(mon_exp));
      end
    end
  end

  initial begin
    rst                    = 1'b1;
    blink_in               = 1'b1;
    clear_in               = 1'b0;
    period_if.period_ready = 1'b1;

    hold(1, 3, 1, 1);
    hold(1, 3, 1, 0);
    hold(0, 4, 1, 0);
    pulses(8, 8, 6, 100, 0);
    for (int i = 0; i < 4; i++) begin
      pulses(5, 5, 1, 100, 0);
      pulses(10, 10, 1, 100, 0);
    end
    pulses(5, 5, 3, 0, 0);
    hold(1, 1, 1, 0);
    hold(1, 2, 0, 0);
    hold(0, Tmo + 5, 1, 0);
    pulses(6, 6, 3, 100, 0);
    pulses(6, 6, 2, 100, 0);
    pulses(6, 6, 1, 100, 1);
    pulses(6, 6, 2, 100, 0);
    hold(1, 3, 1, 0);
    hold(1, 2, 1, 1);
    hold(1, 3, 1, 0);
    hold(0, 4, 1, 0);
    pulses(7, 4, 3, 100, 0);

    for (int i = 0; i < 300; i++) begin
      int hi, lo, pct;
      hi  = $urandom_range(12, 1);
      lo  = ($urandom_range(15) == 0) ? int'(Tmo) + $urandom_range(8) : $urandom_range(12, 1);
      pct = $urandom_range(100);
      pulses(hi, lo, 1, pct, $urandom_range(15) == 0);
      if ($urandom_range(63) == 0) hold($urandom_range(1), 2, 1, 1);
    end
    hold(0, 5, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
